// File: rtl/mat_pkg.sv
// Shared widths and arbiter state encoding for the matrix read path.
package mat_pkg;

    localparam int DIM_WIDTH  = 3;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } arb_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting index after last_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    int cand;

    // Scan starting one past the previous winner so it gets lowest priority.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mat_rd_arbiter.sv
// Round-robin arbiter granting several requesters single-element reads
// from shared matrix storage, with a per-access timeout and abort.
module mat_rd_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DIM_WIDTH  = mat_pkg::DIM_WIDTH,
    parameter int DATA_WIDTH = mat_pkg::DATA_WIDTH,
    parameter int TIMEOUT    = 15,
    localparam int GID_W     = mat_pkg::idx_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_rd_en,
    input  logic [NUM_REQ-1:0]             req_slot,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]   req_row,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]   req_col,
    output logic [DATA_WIDTH-1:0]          req_elem,
    output logic [NUM_REQ-1:0]             req_elem_valid,
    output logic [NUM_REQ-1:0]             req_timeout,
    output logic                           mem_rd_en,
    output logic                           mem_slot_idx,
    output logic [DIM_WIDTH-1:0]           mem_row_idx,
    output logic [DIM_WIDTH-1:0]           mem_col_idx,
    input  logic [DATA_WIDTH-1:0]          mem_rd_elem,
    input  logic                           mem_rd_elem_valid,
    output logic                           busy,
    output logic [GID_W-1:0]               grant_id
);

    import mat_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e             state_q;
    logic [GID_W-1:0]       grant_id_q;
    logic [GID_W-1:0]       last_grant_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   mem_rd_en_q;
    logic                   mem_slot_q;
    logic [DIM_WIDTH-1:0]   mem_row_q;
    logic [DIM_WIDTH-1:0]   mem_col_q;
    logic [DATA_WIDTH-1:0]  elem_q;
    logic [NUM_REQ-1:0]     elem_vld_q;
    logic [NUM_REQ-1:0]     tmo_q;

    logic                   pick_found;
    logic [GID_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic                   req_held;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_rr_pick (
        .req_i   (req_rd_en),
        .last_i  (last_grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_onehot = NUM_REQ'(1) << grant_id_q;
    // The granted requester still wants the access (or has not yet let go).
    assign req_held     = |(req_rd_en & grant_onehot);

    // Arbitration FSM; every output is a register so the memory sees clean edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_slot_q   <= 1'b0;
            mem_row_q    <= '0;
            mem_col_q    <= '0;
            elem_q       <= '0;
            elem_vld_q   <= '0;
            tmo_q        <= '0;
        end else begin
            elem_vld_q <= '0;
            tmo_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id_q  <= pick_idx;
                        mem_slot_q  <= req_slot[pick_idx];
                        mem_row_q   <= req_row[pick_idx*DIM_WIDTH +: DIM_WIDTH];
                        mem_col_q   <= req_col[pick_idx*DIM_WIDTH +: DIM_WIDTH];
                        mem_rd_en_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!req_held) begin
                        // Requester gave up: drop silently, fairness pointer untouched.
                        mem_rd_en_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (mem_rd_elem_valid) begin
                        // Data beats the timeout when both land on the same cycle.
                        elem_q       <= mem_rd_elem;
                        elem_vld_q   <= grant_onehot;
                        last_grant_q <= grant_id_q;
                        mem_rd_en_q  <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tmo_q        <= grant_onehot;
                        last_grant_q <= grant_id_q;
                        mem_rd_en_q  <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!req_held) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_elem       = elem_q;
    assign req_elem_valid = elem_vld_q;
    assign req_timeout    = tmo_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_slot_idx   = mem_slot_q;
    assign mem_row_idx    = mem_row_q;
    assign mem_col_idx    = mem_col_q;
    assign grant_id       = grant_id_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/mat_rd_arbiter.md
MAT_RD_ARBITER -- requirements
Module: mat_rd_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 3, number of requesters; DIM_WIDTH, default 3, row/col index width; DATA_WIDTH, default 8, element width; TIMEOUT, default 15, max GRANT cycles awaiting storage.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_rd_en  in  NUM_REQ  per-requester read request, level.
- req_slot  in  NUM_REQ  per-requester slot index.
- req_row  in  NUM_REQ*DIM_WIDTH  packed row indices; requester i at [i*DIM_WIDTH +: DIM_WIDTH].
- req_col  in  NUM_REQ*DIM_WIDTH  packed column indices, same packing.
- req_elem  out  DATA_WIDTH  element returned to the granted requester.
- req_elem_valid  out  NUM_REQ  one-hot, 1-cycle pulse.
- req_timeout  out  NUM_REQ  one-hot, 1-cycle pulse.
- mem_rd_en  out  1  storage read enable.
- mem_slot_idx  out  1  storage slot.
- mem_row_idx, mem_col_idx  out  DIM_WIDTH each  storage address.
- mem_rd_elem  in  DATA_WIDTH  storage data.
- mem_rd_elem_valid  in  1  storage data valid.
- busy  out  1  high in any state other than S_IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.

Function
REQ-003 States SHALL be S_IDLE, S_GRANT, and S_RELEASE.
REQ-004 In S_IDLE with at least one req_rd_en bit high, the block SHALL select the first requesting index after last_grant, wrapping modulo NUM_REQ (round-robin). It SHALL register the winner's slot/row/col onto mem_*, set grant_id, and enter S_GRANT on the next edge.
REQ-005 mem_rd_en SHALL be 1 only in S_GRANT and 0 in S_IDLE and S_RELEASE, so every access presents a fresh rising edge.
REQ-006 mem_slot_idx, mem_row_idx and mem_col_idx SHALL hold constant from grant entry until the return to S_IDLE.
REQ-007 In S_GRANT, when mem_rd_elem_valid=1, the block SHALL on the next edge capture mem_rd_elem into req_elem, pulse req_elem_valid[grant_id] for exactly one cycle, set last_grant=grant_id, and enter S_RELEASE.
REQ-008 Latency SHALL be: request-to-mem_rd_en is 1 cycle; mem valid to req_elem_valid is 1 cycle.
REQ-009 req_elem SHALL hold its value until the next capture.
REQ-010 In S_GRANT, a cycle counter SHALL increment each cycle. On reaching TIMEOUT without valid, the block SHALL pulse req_timeout[grant_id], leave req_elem unchanged, set last_grant, and enter S_RELEASE.
REQ-011 If req_rd_en[grant_id] drops in S_GRANT before valid, the block SHALL abort to S_IDLE with no valid or timeout pulse and leave last_grant unchanged.
REQ-012 If valid and the timeout condition coincide in the same cycle, valid SHALL win and no timeout pulse SHALL be issued.
REQ-013 S_RELEASE SHALL remain until req_rd_en[grant_id]=0, then enter S_IDLE. Arbitration SHALL occur only in S_IDLE, giving a minimum of 1 idle cycle between accesses.
REQ-014 mem_rd_elem_valid SHALL be ignored outside S_GRANT.
REQ-015 Non-granted requesters SHALL see no valid or timeout pulses; their req_rd_en SHALL simply stay pending.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set: state S_IDLE; all outputs 0; grant_id 0; last_grant NUM_REQ-1 (so requester 0 wins first); counter 0.
REQ-017 Reset asserted mid-access SHALL drop mem_rd_en on the next edge and discard any in-flight result without emitting a pulse.

Structure
REQ-018 Package mat_pkg SHALL hold DIM_WIDTH, DATA_WIDTH, and the arbiter state encodings (S_IDLE=2'd0, S_GRANT=2'd1, S_RELEASE=2'd2).
REQ-019 The round-robin selection SHALL be a combinational sub-module, rr_pick. It SHALL take (req vector, last_grant) and return (found, index).

Verification
REQ-020 The bench SHALL cover a single request with 1-cycle memory: req0 reads slot1 (2,3) with mem latency 1 and data 8'h5A. Required: mem_rd_en high 1 cycle after the request, req_elem=8'h5A, req_elem_valid=3'b001 for 1 cycle, then S_RELEASE until req0 drops.
REQ-021 The bench SHALL cover round-robin ordering: req0, req1 and req2 all held high continuously, each dropping after its valid. Required grant order: 0, 1, 2, 0 with no starvation.
REQ-022 The bench SHALL cover timeout: memory never asserts valid. Required: req_timeout[g] pulses exactly TIMEOUT=15 cycles after grant entry, followed by a return to S_IDLE once the requester releases.
REQ-023 The bench SHALL cover coincident valid and timeout: valid arrives on the timeout cycle. Required: valid pulse only, no timeout pulse.
REQ-024 The bench SHALL cover abort and reset: req1 drops in S_GRANT, giving S_IDLE with no pulse and last_grant unchanged; rst during S_GRANT gives all outputs 0 on the next edge and req0 winning the next contest.
REQ-025 The bench SHALL cover interaction with the matrix-add engine: two operator units, each reading 2x3 matrices through the arbiter. Required: every element is delivered to the correct requester, and both results match the golden A+B.
